// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg
// Shared types and constants for the frame scheduler.
//   sched_state_t   : FSM state encoding (IDLE, LOGIC, DRAW, READY)
//   DEFAULT_TIMEOUT : default watchdog limit per phase, in clock cycles
//                     (20 ms at 50 MHz)
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOGIC = 2'd1,
        DRAW  = 2'd2,
        READY = 2'd3
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 1000000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
// Ports:
//   clock  : system clock
//   reset  : synchronous reset, active-high (count -> 0)
//   clear  : synchronous clear (count -> 0), wins over en
//   en     : count one step this cycle
//   count  : current value, W bits
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Sequences one frame of work per vertical sync: starts game logic, then
// the entity drawer, and swaps the entity double buffer only when the
// previous frame's work finished in time. next_screen pulses that land
// while work is still running are counted as dropped frames.
//
// Optional feature: define FRAME_SCHED_WATCHDOG_EN to add a per-phase
// watchdog that abandons a stuck LOGIC/DRAW phase after TIMEOUT cycles
// and raises the sticky timeout_err flag. Without it, timeout_err is 0
// and LOGIC/DRAW wait indefinitely.
//
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   next_screen   : one-cycle frame pulse (already edge-detected)
//   logic_done    : one-cycle pulse, game logic finished
//   draw_done     : one-cycle pulse, entity list written
//   logic_start   : one-cycle pulse, start game logic
//   draw_start    : one-cycle pulse, start entity drawer
//   swap          : one-cycle pulse, swap entity buffers (only with logic_start)
//   busy          : high in LOGIC or DRAW
//   drop_count    : saturating count of next_screen pulses seen while busy
//   timeout_err   : sticky watchdog flag
//   dbg_state     : current FSM state, for observation only
//
// Handshake: all inputs are single-cycle pulses sampled on the rising edge;
// every output pulse is registered and appears exactly one cycle after the
// input that qualified it. There is no back-pressure.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TO_W    = 20,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             next_screen,
    input  logic             logic_done,
    input  logic             draw_done,
    output logic             logic_start,
    output logic             draw_start,
    output logic             swap,
    output logic             busy,
    output logic [CNT_W-1:0] drop_count,
    output logic             timeout_err,
    output sched_state_t     dbg_state
);

    // A limit outside 2..2**TO_W could never be reached by the watchdog.
    if (TO_W < 1 || TO_W > 31 || TIMEOUT < 2 || TIMEOUT > (1 << TO_W)) begin : g_bad_watchdog_cfg
        $error("frame_scheduler: TIMEOUT does not fit in TO_W bits");
    end

    sched_state_t state;
    sched_state_t next_state;

    logic logic_start_d;
    logic draw_start_d;
    logic swap_d;
    logic drop_inc;
    logic timeout_set;
    logic wd_expired;

    assign busy      = (state == LOGIC) || (state == DRAW);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Next-state and pulse decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        logic_start_d = 1'b0;
        draw_start_d  = 1'b0;
        swap_d        = 1'b0;
        drop_inc      = 1'b0;
        timeout_set   = 1'b0;

        case (state)
            IDLE: begin
                // First frame after reset/timeout: nothing drawn yet, no swap.
                if (next_screen) begin
                    logic_start_d = 1'b1;
                    next_state    = LOGIC;
                end
            end

            LOGIC: begin
                // A frame pulse here is an overrun even if logic finishes now.
                drop_inc = next_screen;
                if (logic_done) begin
                    draw_start_d = 1'b1;
                    next_state   = DRAW;
                end else if (wd_expired) begin
                    timeout_set = 1'b1;
                    next_state  = IDLE;
                end
            end

            DRAW: begin
                if (draw_done && next_screen) begin
                    // Drawing finished just in time: the frame is complete.
                    swap_d        = 1'b1;
                    logic_start_d = 1'b1;
                    next_state    = LOGIC;
                end else if (draw_done) begin
                    next_state = READY;
                end else begin
                    drop_inc = next_screen;
                    if (wd_expired) begin
                        timeout_set = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end

            READY: begin
                if (next_screen) begin
                    swap_d        = 1'b1;
                    logic_start_d = 1'b1;
                    next_state    = LOGIC;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            logic_start <= 1'b0;
            draw_start  <= 1'b0;
            swap        <= 1'b0;
        end else begin
            state       <= next_state;
            logic_start <= logic_start_d;
            draw_start  <= draw_start_d;
            swap        <= swap_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_drop_counter (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (drop_inc),
        .count (drop_count)
    );

`ifdef FRAME_SCHED_WATCHDOG_EN
    logic [TO_W-1:0] wd_count;
    logic            timeout_err_q;

    // Every entry into LOGIC or DRAW coincides with a start pulse, so the
    // start decode doubles as the watchdog restart.
    sat_counter #(
        .W (TO_W)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clear (logic_start_d || draw_start_d),
        .en    (busy),
        .count (wd_count)
    );

    assign wd_expired = (wd_count == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
// Directed bench for frame_scheduler: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (basic frame, overrun,
// simultaneous draw_done/next_screen, saturation, watchdog, reset mid-DRAW).
// Inputs are driven 1 ns after the rising edge and outputs are sampled
// 1 ns after the following rising edge.
module tb_frame_scheduler;
    import frame_sched_pkg::*;

    localparam int TB_CNT_W   = 2;
    localparam int TB_TO_W    = 7;
    localparam int TB_TIMEOUT = 64;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic                next_screen = 1'b0;
    logic                logic_done  = 1'b0;
    logic                draw_done   = 1'b0;
    logic                logic_start;
    logic                draw_start;
    logic                swap;
    logic                busy;
    logic [TB_CNT_W-1:0] drop_count;
    logic                timeout_err;
    sched_state_t        dbg_state;

    frame_scheduler #(
        .CNT_W   (TB_CNT_W),
        .TO_W    (TB_TO_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .next_screen (next_screen),
        .logic_done  (logic_done),
        .draw_done   (draw_done),
        .logic_start (logic_start),
        .draw_start  (draw_start),
        .swap        (swap),
        .busy        (busy),
        .drop_count  (drop_count),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard: expected output word {ls, ds, sw, busy, drop, state, err}
    // ------------------------------------------------------------------
    logic [8:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic expect_outs(input logic ls, input logic ds, input logic sw,
                               input logic bsy, input logic [1:0] drop,
                               input logic [1:0] st, input logic err);
        exp_q.push_back({ls, ds, sw, bsy, drop, st, err});
    endtask

    task automatic check_outs(input string name);
        logic [8:0] exp_w;
        logic [8:0] act_w;
        exp_w = exp_q.pop_front();
        act_w = {logic_start, draw_start, swap, busy, drop_count, dbg_state, timeout_err};
        total++;
        if (act_w !== exp_w) begin
            bad++;
            $display("FAIL %s: got ls/ds/sw/busy/drop/st/err=%b required %b", name, act_w, exp_w);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, act, exp_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input logic ns, input logic ld, input logic dd);
        next_screen = ns;
        logic_done  = ld;
        draw_done   = dd;
        @(posedge clock);
        #1;
        next_screen = 1'b0;
        logic_done  = 1'b0;
        draw_done   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       rst;
        logic       ns;
        logic       ld;
        logic       dd;
        logic       ls;
        logic       ds;
        logic       sw;
        logic       bsy;
        logic [1:0] drop;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic ns, input logic ld, input logic dd,
                           input logic ls, input logic ds, input logic sw, input logic bsy,
                           input logic [1:0] drop, input sched_state_t st);
        vec_t v;
        v = '{rst: rst, ns: ns, ld: ld, dd: dd, ls: ls, ds: ds, sw: sw,
              bsy: bsy, drop: drop, st: st};
        vecs.push_back(v);
    endtask

    // Global time guard.
    initial begin
        #200000;
        $display("FAIL sim_timeout: bench still running at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        //       rst ns ld dd | ls ds sw busy drop state
        add_vec(1, 0, 0, 0,   0, 0, 0, 0, 2'd0, IDLE);   // reset state
        add_vec(0, 0, 0, 1,   0, 0, 0, 0, 2'd0, IDLE);   // stray draw_done in IDLE
        add_vec(0, 0, 1, 0,   0, 0, 0, 0, 2'd0, IDLE);   // stray logic_done in IDLE
        add_vec(0, 1, 0, 0,   1, 0, 0, 1, 2'd0, LOGIC);  // first frame, no swap
        add_vec(0, 0, 0, 0,   0, 0, 0, 1, 2'd0, LOGIC);
        add_vec(0, 0, 0, 1,   0, 0, 0, 1, 2'd0, LOGIC);  // stray draw_done in LOGIC
        add_vec(0, 0, 1, 0,   0, 1, 0, 1, 2'd0, DRAW);
        add_vec(0, 1, 0, 0,   0, 0, 0, 1, 2'd1, DRAW);   // overrun in DRAW
        add_vec(0, 0, 0, 1,   0, 0, 0, 0, 2'd1, READY);
        add_vec(0, 0, 1, 0,   0, 0, 0, 0, 2'd1, READY);  // stray logic_done in READY
        add_vec(0, 1, 0, 0,   1, 0, 1, 1, 2'd1, LOGIC);  // swap with logic_start
        add_vec(0, 1, 1, 0,   0, 1, 0, 1, 2'd2, DRAW);   // drop counted and advance
        add_vec(0, 1, 0, 1,   1, 0, 1, 1, 2'd2, LOGIC);  // simultaneous: complete frame
        add_vec(0, 1, 0, 0,   0, 0, 0, 1, 2'd3, LOGIC);
        add_vec(0, 1, 0, 0,   0, 0, 0, 1, 2'd3, LOGIC);  // saturated
        add_vec(0, 0, 1, 0,   0, 1, 0, 1, 2'd3, DRAW);
        add_vec(1, 0, 0, 1,   0, 0, 0, 0, 2'd0, IDLE);   // reset wins over draw_done
        add_vec(0, 1, 0, 0,   1, 0, 0, 1, 2'd0, LOGIC);  // restart without swap

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            step(vecs[i].ns, vecs[i].ld, vecs[i].dd);
            reset = 1'b0;
            expect_outs(vecs[i].ls, vecs[i].ds, vecs[i].sw, vecs[i].bsy,
                        vecs[i].drop, vecs[i].st, 1'b0);
            check_outs($sformatf("table[%0d]", i));
        end

        // ---------------- basic frame ----------------
        apply_reset();
        step(1'b1, 1'b0, 1'b0);                        // next_screen at t0
        expect_outs(1, 0, 0, 1, 2'd0, LOGIC, 0);
        check_outs("basic logic_start t0+1");
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);                        // logic_done at t0+10
        expect_outs(0, 1, 0, 1, 2'd0, DRAW, 0);
        check_outs("basic draw_start t0+11");
        repeat (19) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);                        // draw_done at t0+30
        for (int c = 31; c <= 100; c++) begin
            check_bit($sformatf("basic busy low t0+%0d", c), busy, 1'b0);
            if (c < 100) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);                        // next_screen at t0+100
        expect_outs(1, 0, 1, 1, 2'd0, LOGIC, 0);
        check_outs("basic swap+logic_start t0+101");

        // ---------------- overrun ----------------
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (49) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);                        // second next_screen at t0+50
        expect_outs(0, 0, 0, 1, 2'd1, LOGIC, 0);
        check_outs("overrun no swap t0+51");
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);                        // logic_done at t0+60
        expect_outs(0, 1, 0, 1, 2'd1, DRAW, 0);
        check_outs("overrun draw_start t0+61");

        // ---------------- simultaneous draw_done + next_screen ----------------
        step(1'b1, 1'b0, 1'b1);
        expect_outs(1, 0, 1, 1, 2'd1, LOGIC, 0);
        check_outs("simultaneous swap, no drop");

        // ---------------- saturation ----------------
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0);
            expect_outs(0, 0, 0, 1, (k > 3) ? 2'd3 : 2'(k), LOGIC, 0);
            check_outs($sformatf("saturation drop %0d", k));
        end

        // ---------------- watchdog ----------------
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (TB_TIMEOUT - 1) step(1'b0, 1'b0, 1'b0);
`ifdef FRAME_SCHED_WATCHDOG_EN
        expect_outs(0, 0, 0, 1, 2'd0, LOGIC, 0);
        check_outs("watchdog still waiting at t0+TIMEOUT");
        step(1'b0, 1'b0, 1'b0);
        expect_outs(0, 0, 0, 0, 2'd0, IDLE, 1);
        check_outs("watchdog expired at t0+TIMEOUT+1");
        step(1'b1, 1'b0, 1'b0);
        expect_outs(1, 0, 0, 1, 2'd0, LOGIC, 1);
        check_outs("watchdog restart without swap");
`else
        repeat (TB_TIMEOUT + 2) step(1'b0, 1'b0, 1'b0);
        expect_outs(0, 0, 0, 1, 2'd0, LOGIC, 0);
        check_outs("no watchdog: LOGIC waits");
`endif

        // ---------------- reset mid-DRAW ----------------
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_outs(0, 1, 0, 1, 2'd0, DRAW, 0);
        check_outs("mid-draw setup");
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        expect_outs(0, 0, 0, 0, 2'd0, IDLE, 0);
        check_outs("reset mid-draw");
        step(1'b0, 1'b0, 1'b0);
        expect_outs(0, 0, 0, 0, 2'd0, IDLE, 0);
        check_outs("no swap after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
